// File: rtl/vga_arbiter_pkg.sv
// Shared game constants: requester/burst defaults, plot field widths and
// the arbiter FSM encodings.
package vga_arbiter_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int BURST_MAX_DEF = 32;
    localparam int COORD_W       = 7;
    localparam int COLOUR_W      = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/vga_arbiter_if.sv
// Bundle between the sprite requesters and the VGA plot port arbiter.
interface vga_arbiter_if
    import vga_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
);

    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          req_done;
    logic [COORD_W*N_REQ-1:0]  req_x;
    logic [COORD_W*N_REQ-1:0]  req_y;
    logic [COLOUR_W*N_REQ-1:0] req_c;
    logic [N_REQ-1:0]          req_we;
    logic [N_REQ-1:0]          gnt;
    logic [COORD_W-1:0]        vga_x;
    logic [COORD_W-1:0]        vga_y;
    logic [COLOUR_W-1:0]       vga_c;
    logic                      vga_writeEn;
    logic                      timeout_err;

    // Arbiter side
    modport slave (
        input  req, req_done, req_x, req_y, req_c, req_we,
        output gnt, vga_x, vga_y, vga_c, vga_writeEn, timeout_err
    );

    // Requester side
    modport master (
        output req, req_done, req_x, req_y, req_c, req_we,
        input  gnt, vga_x, vga_y, vga_c, vga_writeEn, timeout_err
    );

endinterface

// File: rtl/vga_arbiter_rr_pick.sv
// Round-robin pick: first set req bit scanning upward from last+1 (wrapping),
// returned one-hot; all zero when nothing is requested.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         win
);

    localparam int LW = $clog2(N_REQ);

    always_comb begin
        logic [LW-1:0] idx;
        logic          found;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = LW'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_arbiter.sv
// Grants the single VGA plot port to one sprite requester at a time,
// round-robin, with a burst timeout and a one-cycle gap between owners.
module vga_arbiter
    import vga_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    vga_arbiter_if.slave  bus
);

    localparam int              LW        = $clog2(N_REQ);
    localparam int              CW        = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(BURST_MAX - 1);
    localparam logic [LW-1:0]   LAST_RST  = LW'(N_REQ - 1);

    logic [1:0]          state_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [CW-1:0]       hold_q;
    logic [LW-1:0]       last_q;
    logic                timeout_q;

    logic [N_REQ-1:0]    win;
    logic [LW-1:0]       gnt_idx;
    logic [COORD_W-1:0]  mux_x;
    logic [COORD_W-1:0]  mux_y;
    logic [COLOUR_W-1:0] mux_c;
    logic                mux_we;
    logic                done_g;
    logic                req_g;
    logic                timeout_hit;
    logic                busy;

    function automatic logic [CW-1:0] hold_sat_inc(input logic [CW-1:0] h);
        return (h == HOLD_LAST) ? h : h + 1'b1;
    endfunction

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req  (bus.req),
        .last (last_q),
        .win  (win)
    );

    // Only the granted slice reaches the plot port; gnt is one-hot so an OR-mux suffices.
    always_comb begin
        mux_x   = '0;
        mux_y   = '0;
        mux_c   = '0;
        mux_we  = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                mux_x   = mux_x | bus.req_x[COORD_W*i +: COORD_W];
                mux_y   = mux_y | bus.req_y[COORD_W*i +: COORD_W];
                mux_c   = mux_c | bus.req_c[COLOUR_W*i +: COLOUR_W];
                mux_we  = mux_we | bus.req_we[i];
                gnt_idx = LW'(i);
            end
        end
    end

    assign busy        = (state_q == ST_BUSY);
    assign done_g      = |(bus.req_done & gnt_q);
    assign req_g       = |(bus.req & gnt_q);
    assign timeout_hit = (hold_q == HOLD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            hold_q    <= '0;
            last_q    <= LAST_RST;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_q <= ST_BUSY;
                        gnt_q   <= win;
                        hold_q  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (done_g || !req_g || timeout_hit) begin
                        state_q <= ST_GAP;
                        gnt_q   <= '0;
                        last_q  <= gnt_idx;
                        // A finished or withdrawn owner is a normal release, not a revoke.
                        if (timeout_hit && !done_g && req_g)
                            timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_sat_inc(hold_q);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.vga_x       = busy ? mux_x  : '0;
    assign bus.vga_y       = busy ? mux_y  : '0;
    assign bus.vga_c       = busy ? mux_c  : '0;
    assign bus.vga_writeEn = busy ? mux_we : 1'b0;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_vga_arbiter.sv
// Directed bench for vga_arbiter: reset, round-robin order, plot mux,
// timeout, done/timeout collision and mid-burst reset abort.
module tb_vga_arbiter;

    logic clk;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt;
    logic [3:0] exp_g;

    vga_arbiter_if #(.N_REQ(4)) bus ();

    vga_arbiter #(.N_REQ(4), .BURST_MAX(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetn       = 1'b1;
        bus.req      = '0;
        bus.req_done = '0;
        bus.req_x    = '0;
        bus.req_y    = '0;
        bus.req_c    = '0;
        bus.req_we   = '0;

        // Reset state, visible before any clock edge
        #1 resetn = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_we", bus.vga_writeEn, 0);
        chk("rst_x", bus.vga_x, 0);
        chk("rst_tmo", bus.timeout_err, 0);
        step();
        step();

        // First grant after reset goes to requester 0, one cycle after sampling
        resetn     = 1'b1;
        bus.req    = 4'b1111;
        bus.req_we = 4'b1111;
        #1;
        chk("lat_idle_gnt", bus.gnt, 0);
        step();
        chk("first_gnt", bus.gnt, 4'b0001);

        // Round-robin with req_done 16 cycles into each grant
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            chk("rr_gnt", bus.gnt, exp_g);
            chk("rr_we", bus.vga_writeEn, 1);
            repeat (15) step();
            bus.req_done = exp_g;
            step();
            bus.req_done = '0;
            chk("gap_gnt", bus.gnt, 0);
            chk("gap_we", bus.vga_writeEn, 0);
            step();
            step();
        end
        chk("rr_wrap", bus.gnt, 4'b0001);
        bus.req = '0;
        step();
        step();

        // Mux: only requester 2, other slices carry junk
        bus.req_x  = {7'h7F, 7'd40, 7'h7F, 7'h7F};
        bus.req_y  = {7'h55, 7'd17, 7'h55, 7'h55};
        bus.req_c  = {3'b111, 3'b101, 3'b010, 3'b010};
        bus.req_we = 4'b1111;
        bus.req    = 4'b0100;
        #1;
        chk("idle_x0", bus.vga_x, 0);
        step();
        chk("mux_gnt", bus.gnt, 4'b0100);
        chk("mux_x", bus.vga_x, 40);
        chk("mux_y", bus.vga_y, 17);
        chk("mux_c", bus.vga_c, 3'b101);
        chk("mux_we", bus.vga_writeEn, 1);
        bus.req_we = 4'b1011;
        #1;
        chk("mux_we_off", bus.vga_writeEn, 0);
        bus.req_done = 4'b1011;
        step();
        bus.req_done = '0;
        chk("ign_done", bus.gnt, 4'b0100);
        bus.req = '0;
        step();
        chk("wd_gnt", bus.gnt, 0);
        chk("wd_x", bus.vga_x, 0);
        step();

        // Timeout: requester 1 never finishes
        bus.req_x  = '0;
        bus.req_y  = '0;
        bus.req_c  = '0;
        bus.req_we = '0;
        bus.req    = 4'b0010;
        step();
        chk("tmo_gnt", bus.gnt, 4'b0010);
        cnt = 0;
        while (bus.gnt != 0 && cnt < 40) begin
            cnt++;
            step();
        end
        chk("tmo_cycles", cnt, 32);
        chk("tmo_flag", bus.timeout_err, 1);
        bus.req = '0;
        step();
        step();
        chk("tmo_sticky", bus.timeout_err, 1);
        resetn = 1'b0;
        #1;
        chk("tmo_clr", bus.timeout_err, 0);
        step();
        resetn = 1'b1;

        // Collision: req_done on the timeout cycle is a normal release
        bus.req = 4'b0001;
        step();
        repeat (31) step();
        chk("col_hold", bus.gnt, 4'b0001);
        bus.req_done = 4'b0001;
        step();
        bus.req_done = '0;
        chk("col_gnt", bus.gnt, 0);
        chk("col_tmo", bus.timeout_err, 0);
        bus.req = '0;
        step();
        step();

        // Abort: reset mid-burst clears the port without a clock edge
        bus.req    = 4'b1111;
        bus.req_we = 4'b1111;
        step();
        chk("ab_gnt", bus.gnt, 4'b0010);
        repeat (3) step();
        chk("ab_we", bus.vga_writeEn, 1);
        resetn = 1'b0;
        #1;
        chk("ab_we_off", bus.vga_writeEn, 0);
        chk("ab_gnt_off", bus.gnt, 0);
        step();
        resetn = 1'b1;
        step();
        chk("ab_restart", bus.gnt, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
